// File: rtl/huff_mem_sequencer_if.sv
// Engine handshake and shared SRAM port bundle for the compression phase sequencer.
// The master side is the sequencer; the slave side is the engines plus SRAM.
interface huff_mem_sequencer_if;
    logic        cnt_start, huff_start, enc_start;
    logic        cnt_done, huff_done, enc_done;
    logic        cnt_read, huff_read, enc_read;
    logic        cnt_write, huff_write, enc_write;
    logic [15:0] cnt_addr, huff_addr, enc_addr;
    logic [7:0]  cnt_wdata, huff_wdata, enc_wdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  rdata;

    modport master (
        output cnt_start, huff_start, enc_start,
        input  cnt_done, huff_done, enc_done,
        input  cnt_read, huff_read, enc_read,
        input  cnt_write, huff_write, enc_write,
        input  cnt_addr, huff_addr, enc_addr,
        input  cnt_wdata, huff_wdata, enc_wdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata,
        output rdata
    );

    modport slave (
        input  cnt_start, huff_start, enc_start,
        output cnt_done, huff_done, enc_done,
        output cnt_read, huff_read, enc_read,
        output cnt_write, huff_write, enc_write,
        output cnt_addr, huff_addr, enc_addr,
        output cnt_wdata, huff_wdata, enc_wdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata,
        input  rdata
    );
endinterface

// File: rtl/huff_mem_sequencer.sv
// Phase controller for COUNT -> TREE -> ENCODE on one shared SRAM port, with
// per-phase write windows, read/write conflict detection and a watchdog.
module huff_mem_sequencer #(
    parameter int unsigned NCHAR     = 45,
    parameter int unsigned CODE_BASE = 90,
    parameter logic [15:0] OUT_BASE  = 16'h0200,
    parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [2:0] phase,
    huff_mem_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCount  = 3'd1,
        StTree   = 3'd2,
        StEncode = 3'd3,
        StDone   = 3'd4,
        StErr    = 3'd5
    } state_e;

    // Exclusive upper bounds, one bit wider than the address to avoid wrap.
    localparam logic [16:0] CntEnd  = 17'(2 * NCHAR);
    localparam logic [16:0] TreeLo  = 17'(CODE_BASE);
    localparam logic [16:0] TreeEnd = 17'(CODE_BASE + 3 * NCHAR);

    state_e      state_q;
    logic [23:0] wdog_q;
    logic [1:0]  err_q;
    logic        cnt_start_q, enc_start_q;

    logic        sel_rd, sel_wr, in_window;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        conflict, violation, phase_done, wdog_expired;

    always_comb begin
        sel_rd     = 1'b0;
        sel_wr     = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        in_window  = 1'b0;
        phase_done = 1'b0;
        case (state_q)
            StCount: begin
                sel_rd     = bus.cnt_read;
                sel_wr     = bus.cnt_write;
                sel_addr   = bus.cnt_addr;
                sel_wdata  = bus.cnt_wdata;
                in_window  = {1'b0, bus.cnt_addr} < CntEnd;
                phase_done = bus.cnt_done;
            end
            StTree: begin
                sel_rd     = bus.huff_read;
                sel_wr     = bus.huff_write;
                sel_addr   = bus.huff_addr;
                sel_wdata  = bus.huff_wdata;
                in_window  = ({1'b0, bus.huff_addr} >= TreeLo) &&
                             ({1'b0, bus.huff_addr} < TreeEnd);
                phase_done = bus.huff_done;
            end
            StEncode: begin
                sel_rd     = bus.enc_read;
                sel_wr     = bus.enc_write;
                sel_addr   = bus.enc_addr;
                sel_wdata  = bus.enc_wdata;
                in_window  = bus.enc_addr >= OUT_BASE;
                phase_done = bus.enc_done;
            end
            default: ;
        endcase
    end

    assign conflict     = sel_rd & sel_wr;
    assign violation    = conflict | (sel_wr & ~in_window);
    assign wdog_expired = (wdog_q == TIMEOUT - 24'd1);

    // A violating access is squashed so it never reaches the SRAM.
    assign bus.mem_read  = sel_rd & ~violation;
    assign bus.mem_write = sel_wr & ~violation;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.rdata     = bus.mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wdog_q      <= '0;
            err_q       <= 2'd0;
            cnt_start_q <= 1'b0;
            enc_start_q <= 1'b0;
        end else begin
            cnt_start_q <= 1'b0;
            enc_start_q <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                wdog_q  <= '0;
                err_q   <= 2'd0;
            end else begin
                case (state_q)
                    StIdle, StDone: begin
                        if (start) begin
                            state_q     <= StCount;
                            wdog_q      <= '0;
                            err_q       <= 2'd0;
                            cnt_start_q <= 1'b1;
                        end
                    end
                    StCount, StTree, StEncode: begin
                        if (violation) begin
                            state_q <= StErr;
                            err_q   <= conflict ? 2'd3 : 2'd1;
                        end else if (phase_done) begin
                            wdog_q <= '0;
                            if (state_q == StCount) begin
                                state_q <= StTree;
                            end else if (state_q == StTree) begin
                                state_q     <= StEncode;
                                enc_start_q <= 1'b1;
                            end else begin
                                state_q <= StDone;
                            end
                        end else if (wdog_expired) begin
                            state_q <= StErr;
                            err_q   <= 2'd2;
                        end else begin
                            wdog_q <= wdog_q + 24'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy           = (state_q == StCount) || (state_q == StTree) || (state_q == StEncode);
    assign done           = (state_q == StDone);
    assign error          = (state_q == StErr);
    assign phase          = state_q;
    assign err_code       = err_q;
    assign bus.cnt_start  = cnt_start_q;
    assign bus.huff_start = (state_q == StTree);
    assign bus.enc_start  = enc_start_q;

endmodule

// File: tb/tb_huff_mem_sequencer.sv
// Directed bench for huff_mem_sequencer: nominal run, windows, conflicts,
// timeout (second instance with a short watchdog), async reset and rerun.
module tb_huff_mem_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort, start2, abort2;
    logic       busy, done, error, busy2, done2, error2;
    logic [1:0] err_code, err_code2;
    logic [2:0] phase, phase2;

    int checks = 0;
    int errors = 0;
    int n_cs = 0, n_hs = 0, n_es = 0;
    int n_enc;

    huff_mem_sequencer_if bus ();
    huff_mem_sequencer_if bus2 ();

    huff_mem_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .phase(phase),
        .bus(bus)
    );

    huff_mem_sequencer #(.TIMEOUT(24'd16)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .error(error2), .err_code(err_code2), .phase(phase2),
        .bus(bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample the engine start outputs just after the edge.
    task tick();
        @(posedge clk);
        #1;
        n_cs += int'(bus.cnt_start);
        n_hs += int'(bus.huff_start);
        n_es += int'(bus.enc_start);
    endtask

    task clear_eng();
        {bus.cnt_done, bus.huff_done, bus.enc_done} = '0;
        {bus.cnt_read, bus.huff_read, bus.enc_read} = '0;
        {bus.cnt_write, bus.huff_write, bus.enc_write} = '0;
        {bus.cnt_addr, bus.huff_addr, bus.enc_addr} = '0;
        {bus.cnt_wdata, bus.huff_wdata, bus.enc_wdata} = '0;
        bus.mem_rdata = '0;
        {bus2.cnt_done, bus2.huff_done, bus2.enc_done} = '0;
        {bus2.cnt_read, bus2.huff_read, bus2.enc_read} = '0;
        {bus2.cnt_write, bus2.huff_write, bus2.enc_write} = '0;
        {bus2.cnt_addr, bus2.huff_addr, bus2.enc_addr} = '0;
        {bus2.cnt_wdata, bus2.huff_wdata, bus2.enc_wdata} = '0;
        bus2.mem_rdata = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        clear_eng();
        #1;
        chk("reset_phase", 32'(phase), 32'd0);
        chk("reset_status", {busy, done, error, err_code}, 32'd0);
        chk("reset_starts", {bus.cnt_start, bus.huff_start, bus.enc_start}, 32'd0);
        chk("reset_mem", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_hold", 32'(phase), 32'd0);

        // Nominal run: engines finish 50 / 400 / 120 cycles after their start.
        n_cs = 0; n_hs = 0; n_es = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("count_entry_phase", 32'(phase), 32'd1);
        chk("count_entry_cnt_start", 32'(bus.cnt_start), 32'd1);
        chk("count_busy", 32'(busy), 32'd1);
        bus.cnt_read = 1'b1; bus.cnt_addr = 16'h0010; bus.mem_rdata = 8'hA5;
        #1;
        chk("count_rd_pass", {bus.mem_read, bus.mem_write, bus.mem_addr}, {14'd0, 2'b10, 16'h0010});
        chk("count_rdata", 32'(bus.rdata), 32'hA5);
        bus.cnt_read = 1'b0; bus.cnt_write = 1'b1; bus.cnt_addr = 16'd89; bus.cnt_wdata = 8'h3C;
        #1;
        chk("count_wr_edge", {bus.mem_write, bus.mem_addr, bus.mem_wdata}, {7'd0, 1'b1, 16'd89, 8'h3C});
        bus.cnt_write = 1'b0;
        bus.huff_done = 1'b1;
        tick();
        bus.huff_done = 1'b0;
        chk("foreign_done_ignored", 32'(phase), 32'd1);
        chk("cnt_start_dropped", 32'(bus.cnt_start), 32'd0);
        repeat (48) tick();
        bus.cnt_done = 1'b1;
        tick();
        bus.cnt_done = 1'b0;
        chk("tree_entry_phase", 32'(phase), 32'd2);
        bus.huff_write = 1'b1; bus.huff_addr = 16'd224; bus.huff_wdata = 8'h5A;
        #1;
        chk("tree_wr_edge_ok", {bus.mem_write, bus.mem_addr, bus.mem_wdata}, {7'd0, 1'b1, 16'd224, 8'h5A});
        bus.huff_write = 1'b0;
        repeat (399) tick();
        bus.huff_done = 1'b1;
        tick();
        bus.huff_done = 1'b0;
        chk("encode_entry_phase", 32'(phase), 32'd3);
        chk("huff_start_span", 32'(n_hs), 32'd400);
        chk("huff_start_low_enc", 32'(bus.huff_start), 32'd0);
        chk("enc_start_first", 32'(bus.enc_start), 32'd1);
        bus.enc_write = 1'b1; bus.enc_addr = 16'h0200; bus.enc_wdata = 8'hC3;
        #1;
        chk("enc_wr_base_ok", {bus.mem_write, bus.mem_addr, bus.mem_wdata}, {7'd0, 1'b1, 16'h0200, 8'hC3});
        bus.enc_write = 1'b0;
        repeat (119) tick();
        bus.enc_done = 1'b1;
        tick();
        bus.enc_done = 1'b0;
        chk("done_phase", 32'(phase), 32'd4);
        chk("done_status", {busy, done, error, err_code}, 32'b01000);
        chk("cnt_start_pulses", 32'(n_cs), 32'd1);
        chk("enc_start_pulses", 32'(n_es), 32'd1);
        bus.enc_write = 1'b1; bus.enc_addr = 16'h0300; bus.enc_wdata = 8'h77;
        #1;
        chk("done_mem_quiet", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}, 32'd0);
        bus.enc_write = 1'b0; bus.enc_addr = '0; bus.enc_wdata = '0;

        // Rerun from DONE with short engine latencies.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rerun_count", {29'(phase), err_code}, {27'd0, 3'd1, 2'd0});
        chk("rerun_wdog", 32'(dut.wdog_q), 32'd0);
        bus.cnt_done = 1'b1;  tick(); bus.cnt_done = 1'b0;
        bus.huff_done = 1'b1; tick(); bus.huff_done = 1'b0;
        bus.enc_done = 1'b1;  tick(); bus.enc_done = 1'b0;
        chk("rerun_done", {29'(phase), done}, {26'd0, 3'd4, 1'b1});

        // Read+write conflict with a coincident done: violation wins.
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.cnt_read = 1'b1; bus.cnt_write = 1'b1; bus.cnt_addr = 16'd5; bus.cnt_done = 1'b1;
        #1;
        chk("conflict_squash", {bus.mem_read, bus.mem_write}, 32'd0);
        tick();
        clear_eng();
        chk("conflict_err", {29'(phase), err_code}, {27'd0, 3'd5, 2'd3});
        chk("conflict_no_tree", {error, bus.huff_start}, 32'b10);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_ignores_start", 32'(phase), 32'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_to_idle", {29'(phase), err_code, error}, 32'd0);

        // Write one below the code table in TREE.
        start = 1'b1; tick(); start = 1'b0;
        bus.cnt_done = 1'b1; tick(); bus.cnt_done = 1'b0;
        bus.huff_write = 1'b1; bus.huff_addr = 16'd89;
        #1;
        chk("window_squash", 32'(bus.mem_write), 32'd0);
        tick();
        clear_eng();
        chk("window_err", {29'(phase), err_code}, {27'd0, 3'd5, 2'd1});
        abort = 1'b1; tick(); abort = 1'b0;

        // Asynchronous reset mid-TREE.
        start = 1'b1; tick(); start = 1'b0;
        bus.cnt_done = 1'b1; tick(); bus.cnt_done = 1'b0;
        chk("pre_rst_tree", {29'(phase), bus.huff_start}, {28'd0, 3'd2, 1'b1});
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_huff", 32'(bus.huff_start), 32'd0);
        chk("async_rst_status", {phase, busy, done, error, err_code}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(phase), 32'd0);

        // Timeout on the short-watchdog instance: enc_done never arrives.
        start2 = 1'b1; tick(); start2 = 1'b0;
        bus2.cnt_done = 1'b1;  tick(); bus2.cnt_done = 1'b0;
        bus2.huff_done = 1'b1; tick(); bus2.huff_done = 1'b0;
        n_enc = (phase2 == 3'd3) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (phase2 != 3'd3) break;
            n_enc++;
        end
        chk("timeout_cycles", 32'(n_enc), 32'd16);
        chk("timeout_err", {29'(phase2), err_code2}, {27'd0, 3'd5, 2'd2});
        start2 = 1'b1; tick(); start2 = 1'b0;
        chk("timeout_ignores_start", 32'(phase2), 32'd5);
        abort2 = 1'b1; tick(); abort2 = 1'b0;
        chk("timeout_abort", {29'(phase2), err_code2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/huff_mem_sequencer.md
Name: huff_mem_sequencer

Overview:
- Top-level phase controller for the compression datapath. Runs three engines in order on one shared 64K x 8 SRAM port: frequency counter (COUNT), huffman_heap tree/code builder (TREE), encoder (ENCODE).
- Grants the memory port to exactly one engine at a time.
- Blocks illegal writes outside each phase's write window.
- Runs a per-phase watchdog and reports done or error to the host.

Parameters:
- NCHAR, 45: alphabet size. Frequency table occupies addresses 0..2*NCHAR-1.
- CODE_BASE, 90: first address of the code table (3 bytes per character).
- OUT_BASE, 16'h0200: first address of the encoder output region.
- TIMEOUT, 24'd1000000: maximum cycles allowed in any single phase.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  host start request, sampled in IDLE and DONE
- abort  in  1  host abort, returns the block to IDLE from any state
- busy  out  1  high in COUNT, TREE and ENCODE
- done  out  1  high while in DONE
- error  out  1  high while in ERR
- err_code  out  2  0 none, 1 illegal write address, 2 timeout, 3 read and write asserted together
- phase  out  3  IDLE=0, COUNT=1, TREE=2, ENCODE=3, DONE=4, ERR=5
- cnt_start / huff_start / enc_start  out  1 each  engine start signals
- cnt_done / huff_done / enc_done  in  1 each  engine completion
- {cnt,huff,enc}_read, {cnt,huff,enc}_write  in  1 each  engine memory strobes
- {cnt,huff,enc}_addr  in  16 each  engine addresses
- {cnt,huff,enc}_wdata  in  8 each  engine write data
- mem_read, mem_write  out  1  SRAM strobes
- mem_addr  out  16  SRAM address
- mem_wdata  out  8  SRAM write data
- mem_rdata  in  8  SRAM read data
- rdata  out  8  mem_rdata passed combinationally to all engines

Behaviour:
Reset
- rst forces state=IDLE, watchdog=0, err_code=0.
- All outputs are 0 during and after reset. This holds when rst is asserted mid-phase.

State transitions
- IDLE: start && !abort -> COUNT.
- COUNT: cnt_done -> TREE.
- TREE: huff_done -> ENCODE.
- ENCODE: enc_done -> DONE.
- DONE: start -> COUNT (new run); err_code is cleared on that transition.
- ERR: held until abort or rst; start is ignored.
- abort in any state -> IDLE next cycle, takes priority over every other event.

Engine start signals
- cnt_start and enc_start are registered one-cycle pulses in the first cycle of COUNT and ENCODE.
- huff_start is a level, held high for the whole of TREE; huffman_heap requires a level start.

Done handling
- A done input is honoured only in its own phase; done inputs from other engines are ignored.
- The phase advances on the clock edge after done is seen.

Memory port
- mem_* is a combinational mux of the active engine's strobes, address and write data, selected by the registered state.
- In IDLE, DONE and ERR, mem_read=mem_write=0 and mem_addr=mem_wdata=0.
- Write windows (inclusive):
  - COUNT: 0..2*NCHAR-1
  - TREE: CODE_BASE..CODE_BASE+3*NCHAR-1
  - ENCODE: OUT_BASE..16'hFFFF
- Reads are unrestricted.
- On a violation in the same cycle, mem_read and mem_write are forced to 0 (the access never reaches SRAM) and the next state is ERR:
  - write outside the active window -> err_code=1
  - read and write asserted together -> err_code=3

Watchdog
- 24-bit counter, cleared on every phase entry, incremented each cycle in COUNT, TREE and ENCODE.
- When it reaches TIMEOUT-1 with no done -> ERR, err_code=2.

Priority when events coincide
- abort > violation > done > timeout.

Status outputs
- busy, done, error and phase are decoded from the registered state.

Test Plan:
- Nominal run: start pulse, model engines assert done 50/400/120 cycles after their start -> cnt_start pulses once at cycle 1, huff_start high for exactly the TREE span, enc_start pulses once, done=1, phase=4; all memory traffic passes through unchanged.
- Window violation: in TREE, huff_write=1 with huff_addr=89 -> mem_write stays 0 that cycle, next cycle phase=5, err_code=1. Same stimulus with huff_addr=224 is allowed to write.
- Conflict and precedence: in COUNT, cnt_read=cnt_write=1 together with cnt_done=1 -> ERR, err_code=3, TREE never entered.
- Timeout: TIMEOUT=16, enc_done never asserted -> ERR on cycle 16 of ENCODE, err_code=2; a later start is ignored; abort -> IDLE with err_code=0.
- Foreign done: huff_done=1 during COUNT -> no phase change; an async rst mid-TREE -> all outputs 0 immediately, huff_start drops without waiting for a clock edge.
- Rerun: from DONE, start=1 -> COUNT with err_code=0 and watchdog=0, and a second full run completes.
